// File: rtl/string_accel_avalon_if.sv
// string_accel_avalon_if: Avalon-MM slave bus for the string accelerator
interface string_accel_avalon_if #(parameter int ADDR_W = 5);
  logic chipselect;
  logic read;
  logic write;
  logic [ADDR_W-1:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master (output chipselect, read, write, address, writedata, input readdata);
  modport slave (input chipselect, read, write, address, writedata, output readdata);
endinterface

// File: rtl/string_accel_avalon.sv
// string_accel_avalon: Avalon-MM STRLEN/STRCMP/STRCHR/TOUPPER engine, one word per clock
// define STRING_ACCEL_IRQ_EN to add the irq port and CTRL[3] IRQ_EN
module string_accel_avalon #(
  parameter int MAX_WORDS = 8,
  parameter int ADDR_W = $clog2(MAX_WORDS) + 2
) (
  input logic clk,
  input logic reset_n,
`ifdef STRING_ACCEL_IRQ_EN
  output logic irq,
`endif
  string_accel_avalon_if.slave bus
);
  localparam int IW = $clog2(MAX_WORDS);
  localparam logic [1:0] OP_LEN = 2'd0, OP_CMP = 2'd1, OP_CHR = 2'd2, OP_UP = 2'd3;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_nxt;
  logic [31:0] buf_a [MAX_WORDS];
  logic [31:0] buf_b [MAX_WORDS];
  logic [1:0] op, region, pos;
  logic [7:0] arg, ca, cb, sa, sb;
  logic [31:0] result, acc, rdata, wa, wb, conv, base, fin_val;
  logic [IW-1:0] idx, widx;
  logic [2:0] cnt;
  logic done, err, irq_en, wr, rd, busy, is_reg, go, collide, hit, term, last, unused_bits;
  assign wr = bus.chipselect && bus.write;
  assign rd = bus.chipselect && bus.read;
  assign busy = state == RUN;
  assign region = bus.address[ADDR_W-1 -: 2];
  assign widx = bus.address[IW-1:0];
  assign is_reg = region == 2'd0 && (widx >> 2) == '0;
  assign go = wr && !busy && is_reg && bus.address[1:0] == 2'd0 && bus.writedata[0];
  assign collide = wr && busy && (region == 2'd1 || region == 2'd2 ||
                   (is_reg && (bus.address[1:0] == 2'd0 || bus.address[1:0] == 2'd3)));
  assign unused_bits = ^bus.writedata[31:8];
`ifdef STRING_ACCEL_IRQ_EN
  assign irq = done && irq_en;
`else
  assign irq_en = 1'b0;
`endif
  always_comb begin
    rdata = region == 2'd1 ? buf_a[widx] : region == 2'd2 ? buf_b[widx] : !is_reg ? '0 :
            bus.address[1:0] == 2'd0 ? {28'd0, irq_en, op, 1'b0} :
            bus.address[1:0] == 2'd1 ? {29'd0, err, done, busy} :
            bus.address[1:0] == 2'd2 ? result : {24'd0, arg};
  end
  // lowest byte position meeting the op's stop condition wins
  always_comb begin
    wa = buf_a[idx];
    wb = buf_b[idx];
    hit = 1'b0;
    pos = 2'd0;
    conv = wa;
    cnt = 3'd0;
    term = 1'b0;
    for (int j = 3; j >= 0; j--) begin
      ca = wa[8*j +: 8];
      cb = wb[8*j +: 8];
      if (op == OP_CMP ? (ca != cb || ca == 8'h00) : op == OP_CHR ? (ca == arg || ca == 8'h00) : ca == 8'h00) begin
        hit = 1'b1;
        pos = 2'(j);
      end
    end
    for (int j = 0; j < 4; j++) begin
      term = term || wa[8*j +: 8] == 8'h00;
      if (!term && wa[8*j +: 8] >= 8'h61 && wa[8*j +: 8] <= 8'h7A) begin
        conv[8*j +: 8] = wa[8*j +: 8] - 8'h20;
        cnt = cnt + 3'd1;
      end
    end
    ca = 8'h00;
    cb = 8'h00;
    sa = wa[{pos, 3'b000} +: 8];
    sb = wb[{pos, 3'b000} +: 8];
    base = 32'({idx, pos});
    last = hit || idx == IW'(MAX_WORDS - 1);
    fin_val = op == OP_LEN ? (hit ? base : 32'(4 * MAX_WORDS)) :
              op == OP_CMP ? (hit ? 32'(sa) - 32'(sb) : 32'd0) :
              op == OP_CHR ? (hit && sa == arg ? base : '1) : acc + 32'(cnt);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = busy ? (last ? FIN : RUN) : (go ? RUN : IDLE);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_WORDS; i++) begin
        buf_a[i] <= '0;
        buf_b[i] <= '0;
      end
      op <= OP_LEN;
      arg <= '0;
      result <= '0;
      acc <= '0;
      done <= 1'b0;
      err <= 1'b0;
      idx <= '0;
      bus.readdata <= '0;
`ifdef STRING_ACCEL_IRQ_EN
      irq_en <= 1'b0;
`endif
    end else begin
      if (rd) bus.readdata <= rdata;
      if (wr && !busy) begin
        if (region == 2'd1) buf_a[widx] <= bus.writedata;
        if (region == 2'd2) buf_b[widx] <= bus.writedata;
        if (is_reg && bus.address[1:0] == 2'd0) begin
          op <= bus.writedata[2:1];
`ifdef STRING_ACCEL_IRQ_EN
          irq_en <= bus.writedata[3];
`endif
        end
        if (is_reg && bus.address[1:0] == 2'd3) arg <= bus.writedata[7:0];
      end
      if (wr && is_reg && bus.address[1:0] == 2'd1) begin
        done <= done && !bus.writedata[1];
        err <= err && !bus.writedata[2];
      end
      if (collide) err <= 1'b1;
      if (go) begin
        done <= 1'b0;
        idx <= '0;
        acc <= '0;
        result <= '0;
      end
      if (busy) begin
        idx <= idx + IW'(1);
        if (op == OP_UP) begin
          buf_a[idx] <= conv;
          acc <= acc + 32'(cnt);
        end
        if (last) begin
          result <= fin_val;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_string_accel_avalon.sv
// tb_string_accel_avalon: directed vectors for string_accel_avalon (MAX_WORDS=8)
module tb_string_accel_avalon;
  localparam int MW = 8;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] d;
`ifdef STRING_ACCEL_IRQ_EN
  logic irq;
`endif
  string_accel_avalon_if #(.ADDR_W(5)) bus ();
  string_accel_avalon #(.MAX_WORDS(MW)) dut (
    .clk(clk),
    .reset_n(reset_n),
`ifdef STRING_ACCEL_IRQ_EN
    .irq(irq),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic bus_wr(input logic [4:0] a, input logic [31:0] v);
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.write = 1'b1;
    bus.address = a;
    bus.writedata = v;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write = 1'b0;
  endtask
  task automatic bus_rd(input logic [4:0] a, output logic [31:0] v);
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.read = 1'b1;
    bus.address = a;
    @(negedge clk);
    v = bus.readdata;
    bus.chipselect = 1'b0;
    bus.read = 1'b0;
  endtask
  task automatic run_op(input string tag, input logic [31:0] ctrl, input int exp_busy, input logic [31:0] exp_res);
    int busy_n;
    logic [31:0] s;
    logic [31:0] r;
    busy_n = 0;
    s = '1;
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.write = 1'b1;
    bus.address = 5'd0;
    bus.writedata = ctrl;
    @(negedge clk);
    bus.write = 1'b0;
    bus.read = 1'b1;
    bus.address = 5'd1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      s = bus.readdata;
      if (!s[0]) break;
      busy_n++;
    end
    bus.chipselect = 1'b0;
    bus.read = 1'b0;
    check({tag, " busy cycles"}, 32'(busy_n), 32'(exp_busy));
    check({tag, " status"}, {29'd0, s[2:0]}, 32'h2);
    bus_rd(5'd2, r);
    check({tag, " result"}, r, exp_res);
  endtask
  task automatic wait_idle(output logic [31:0] s);
    s = '1;
    for (int i = 0; i < 40; i++) begin
      bus_rd(5'd1, s);
      if (!s[0]) break;
    end
  endtask
  initial begin
    bus.chipselect = 1'b0;
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.address = '0;
    bus.writedata = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    bus_rd(5'd1, d); check("rst status", d, 32'h0);
    bus_rd(5'd2, d); check("rst result", d, 32'h0);
    bus_rd(5'd8, d); check("rst a0", d, 32'h0);
    bus_rd(5'd0, d); check("rst ctrl", d, 32'h0);
    bus_wr(5'd8, 32'h6C6C6548);
    bus_wr(5'd9, 32'h0000006F);
    run_op("strlen hello", 32'h1, 2, 32'd5);
    bus_wr(5'd8, 32'h00636261);
    bus_wr(5'd16, 32'h00646261);
    run_op("strcmp abc-abd", 32'h3, 1, 32'hFFFFFFFF);
    bus_wr(5'd16, 32'h00636261);
    run_op("strcmp equal", 32'h3, 1, 32'h0);
    bus_wr(5'd8, 32'h6C6C6548);
    bus_wr(5'd3, 32'h6C);
    run_op("strchr l", 32'h5, 1, 32'd2);
    bus_wr(5'd3, 32'h7A);
    run_op("strchr miss", 32'h5, 2, 32'hFFFFFFFF);
    bus_wr(5'd3, 32'h00);
    run_op("strchr nul", 32'h5, 2, 32'd5);
    run_op("toupper", 32'h7, 2, 32'd4);
    bus_rd(5'd8, d); check("toupper a0", d, 32'h4C4C4548);
    bus_rd(5'd9, d); check("toupper a1", d, 32'h0000004F);
    for (int i = 0; i < MW; i++) bus_wr(5'(8 + i), 32'h41414141);
    run_op("strlen noterm", 32'h1, MW, 32'd32);
    bus_wr(5'd4, 32'hDEADBEEF);
    bus_rd(5'd4, d); check("reserved", d, 32'h0);
    bus_rd(5'd24, d); check("above b", d, 32'h0);
    bus_wr(5'd0, 32'h1);
    bus_wr(5'd8, 32'h12345678);
    bus_wr(5'd0, 32'h1);
    wait_idle(d); check("collision status", d, 32'h6);
    bus_rd(5'd8, d); check("collision a0", d, 32'h41414141);
    bus_wr(5'd1, 32'h6);
    bus_rd(5'd1, d); check("w1c status", d, 32'h0);
    bus_wr(5'd0, 32'h1);
    bus_rd(5'd8, d); check("busy read a0", d, 32'h41414141);
    bus_rd(5'd1, d); check("busy status", d, 32'h1);
    #3 reset_n = 1'b0;
    #1 check("async rst readdata", bus.readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_rd(5'd1, d); check("post-rst status", d, 32'h0);
    bus_rd(5'd2, d); check("post-rst result", d, 32'h0);
    bus_rd(5'd8, d); check("post-rst a0", d, 32'h0);
`ifdef STRING_ACCEL_IRQ_EN
    check("irq after rst", {31'd0, irq}, 32'h0);
    bus_wr(5'd0, 32'h8);
    bus_rd(5'd0, d); check("ctrl irq_en", d, 32'h8);
    run_op("strlen irq", 32'h9, 1, 32'h0);
    check("irq raised", {31'd0, irq}, 32'h1);
    bus_wr(5'd1, 32'h2);
    check("irq cleared", {31'd0, irq}, 32'h0);
`else
    bus_wr(5'd0, 32'h8);
    bus_rd(5'd0, d); check("ctrl bit3 ignored", d, 32'h0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
